// File: rtl/decoder_nx2n_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_nx2n_seq
// Brief    : Registered N-to-2^N one-hot decoder with valid/ready address
//            intake and an optional SCAN walk (enabled by DECODER_SCAN_EN).
// Revision : 1.0 - initial release
// ============================================================================
module decoder_nx2n_seq #(
    parameter int N          = 2,
    parameter int STEP       = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_addr,
    output logic [(2**N)-1:0]   d,
    output logic                out_valid,
    output logic [N-1:0]        cur_addr,
    output logic                scan_wrap
);

    localparam int             c_W        = 2**N;
    localparam logic [c_W-1:0] c_INACTIVE = {c_W{ACTIVE_LOW}};
    localparam logic [N-1:0]   c_ADDR_ONE = N'(1);
    localparam logic [N-1:0]   c_ADDR_MAX = '1;

    // XOR with the inactive pattern flips polarity for active-low builds
    function automatic logic [c_W-1:0] f_decode(input logic [N-1:0] a);
        return ({{(c_W-1){1'b0}}, 1'b1} << a) ^ c_INACTIVE;
    endfunction

`ifdef DECODER_SCAN_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    localparam int              c_CW        = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [c_CW-1:0] c_STEP_LAST = c_CW'(STEP - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

    logic [c_CW-1:0] r_step_cnt;
    logic [c_CW-1:0] w_step_cnt_nxt;
    logic            r_scan_wrap;
    logic            w_scan_wrap_nxt;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam int c_unused_step = STEP;
    logic          w_unused_mode;
    assign w_unused_mode = mode;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_cur_addr;
    logic [N-1:0]    w_cur_addr_nxt;
    logic [N-1:0]    w_addr_inc;
    logic [c_W-1:0]  r_d;
    logic [c_W-1:0]  w_d_nxt;
    logic            w_accept;

`ifdef DECODER_SCAN_EN
    assign in_ready  = en & rst_n & (r_state != S_SCAN);
    assign scan_wrap = r_scan_wrap;
`else
    assign in_ready  = en & rst_n;
    assign scan_wrap = 1'b0;
`endif

    assign w_accept   = in_valid & in_ready;
    assign w_addr_inc = r_cur_addr + c_ADDR_ONE;
    assign d          = r_d;
    assign out_valid  = (r_state != S_IDLE);
    assign cur_addr   = r_cur_addr;

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_addr_nxt = r_cur_addr;
        w_d_nxt        = r_d;
`ifdef DECODER_SCAN_EN
        w_step_cnt_nxt  = r_step_cnt;
        w_scan_wrap_nxt = 1'b0;
`endif
        if (!en) begin
            // disable drops to IDLE but keeps the last address for software
            w_state_nxt = S_IDLE;
            w_d_nxt     = c_INACTIVE;
`ifdef DECODER_SCAN_EN
            w_step_cnt_nxt = '0;
`endif
        end else if (w_accept) begin
            w_cur_addr_nxt = in_addr;
            w_d_nxt        = f_decode(in_addr);
            w_state_nxt    = S_HOLD;
`ifdef DECODER_SCAN_EN
            if (mode) begin
                w_state_nxt    = S_SCAN;
                w_step_cnt_nxt = '0;
            end
`endif
        end
`ifdef DECODER_SCAN_EN
        else if (r_state == S_SCAN) begin
            if (r_step_cnt == c_STEP_LAST) begin
                w_step_cnt_nxt  = '0;
                w_cur_addr_nxt  = w_addr_inc;
                w_d_nxt         = f_decode(w_addr_inc);
                w_scan_wrap_nxt = (r_cur_addr == c_ADDR_MAX);
            end else begin
                w_step_cnt_nxt = r_step_cnt + c_CNT_ONE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cur_addr <= '0;
            r_d        <= c_INACTIVE;
`ifdef DECODER_SCAN_EN
            r_step_cnt  <= '0;
            r_scan_wrap <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cur_addr <= w_cur_addr_nxt;
            r_d        <= w_d_nxt;
`ifdef DECODER_SCAN_EN
            r_step_cnt  <= w_step_cnt_nxt;
            r_scan_wrap <= w_scan_wrap_nxt;
`endif
        end
    end

endmodule
`default_nettype wire
